wrr_pkt_scheduler: RTL and testbench
====================================

Name: wrr_pkt_scheduler

Overview:
Packet-granular weighted round-robin scheduler that decides which input FIFO of the tenant output mux drives the shared master AXI-Stream. It watches per-queue "packet available" requests and the output handshake, and issues a one-hot grant that is held for a whole packet. Each queue may send up to its configured weight in packets per round before the grant moves on. It sits beside the mux datapath and replaces its fixed alternation with configurable per-tenant bandwidth shares.

Parameters:
NUM_QUEUES, 2, number of requesters (1..16)
WEIGHT_WIDTH, 4, bits per weight and credit counter
Q_IDX_WIDTH, log2(NUM_QUEUES) (min 1), width of the queue index

Ports:
axis_aclk  in  1  clock
axis_resetn  in  1  synchronous active-low reset
req  in  NUM_QUEUES  bit i = queue i has at least one complete packet at its head
weights  in  NUM_QUEUES*WEIGHT_WIDTH  weight of queue i in bits [i*W +: W]
weight_load  in  1  one-cycle pulse; capture weights
out_tvalid  in  1  master stream tvalid of the granted queue
out_tready  in  1  master stream tready
out_tlast  in  1  master stream tlast
grant  out  NUM_QUEUES  one-hot grant; all zero when idle
grant_idx  out  Q_IDX_WIDTH  index of the granted or last granted queue
grant_valid  out  1  a grant is active
round_done  out  1  one-cycle pulse when the pointer wraps from NUM_QUEUES-1 to 0

Behaviour:
- Reset (axis_resetn=0 at posedge): state=IDLE, grant=0, grant_valid=0, grant_idx=0, round_done=0, ptr=0, credit=0, all weight registers=1. Reset mid-packet drops the grant immediately. The bench flushes the datapath separately.
- Weight registers capture weights on the edge where weight_load=1. A new value applies at the next selection. An in-flight credit is not changed. Weight 0 means the queue is never selected.
- eop = out_tvalid & out_tready & out_tlast & grant_valid.
- Eligible(i) = req[i] & (weight_reg[i] != 0).
- Selection is a rotating priority search starting at ptr, then ptr+1, and so on modulo NUM_QUEUES. The first eligible queue wins. The search is combinational, and its result is registered.
- States:
  - IDLE:
    - If any queue is eligible, the winner w is granted at the next edge: grant=onehot(w), grant_idx=w, credit=weight_reg[w]-1, state=GRANT.
    - Otherwise stay in IDLE.
    - Latency from req rising in IDLE to grant_valid=1 is 1 cycle.
  - GRANT:
    - grant and grant_valid are held constant. Changes on req are ignored, so packets stay atomic.
    - On eop, go to NEXT. grant and grant_valid go to 0 at the same edge.
    - Without eop, remain in GRANT indefinitely; there is no timeout.
  - NEXT (always exactly one bubble cycle):
    - If req[grant_idx] & credit!=0 & weight_reg[grant_idx]!=0: re-grant the same queue, credit=credit-1, state=GRANT.
    - Otherwise: ptr=grant_idx+1, wrapping at NUM_QUEUES-1 to 0. round_done=1 for that cycle on wrap. state=IDLE.
- credit is unsigned WEIGHT_WIDTH bits. It is never decremented below 0.
- Weight 2^W-1 gives at most 2^W-1 consecutive packets.
- A queue whose req drops while it still holds credit forfeits the remaining credit.
- Simultaneous events:
  - weight_load coinciding with selection: the old weight sets the credit.
  - eop coinciding with weight_load: both take effect.
- grant_valid=0 whenever grant==0. grant never has more than one bit set.
- Sustained per-packet overhead: 1 idle cycle (NEXT) plus, on a queue switch, 1 cycle (IDLE).

Test Plan:
- Reset, then weights={1,1}, both req=1, 3-beat packets → grants alternate q0,q1,q0,q1. round_done pulses after each q1 packet. grant_valid drops for 2 cycles between packets.
- weights: q0=3, q1=1, both req held, 1-beat packets → per round q0,q0,q0,q1. 8 packets give q0=6, q1=2.
- weights: q0=0, q1=2; only req[0]=1 → grant stays 0 indefinitely. Raise req[1] → grant=2'b10 one cycle later.
- During a q0 packet, deassert req[0] and assert req[1] at beat 2 of 4 → q0 grant held until tlast. After NEXT, q1 is granted even though q0 had credit 2 left.
- Pulse weight_load with q0=5 mid-round while q0 has credit 0 → q1 is served next. q0 then gets 5 consecutive packets.
- Assert axis_resetn=0 for 1 cycle during beat 2 of a q1 packet → next cycle grant=0, ptr=0, weights=1. The next selection starts from q0.

Source files
------------

// File: rtl/wrr_pkt_scheduler.sv
// Packet-granular weighted round-robin scheduler for the tenant output mux.
// Grants one queue per packet and lets it send up to its weight in packets before the grant rotates.
module wrr_pkt_scheduler #(
  parameter int NUM_QUEUES   = 2,
  parameter int WEIGHT_WIDTH = 4,
  parameter int Q_IDX_WIDTH  = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_resetn,
  input  logic [NUM_QUEUES-1:0]                req,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0]   weights,
  input  logic                                 weight_load,
  input  logic                                 out_tvalid,
  input  logic                                 out_tready,
  input  logic                                 out_tlast,
  output logic [NUM_QUEUES-1:0]                grant,
  output logic [Q_IDX_WIDTH-1:0]               grant_idx,
  output logic                                 grant_valid,
  output logic                                 round_done
);

  typedef enum logic [1:0] {IDLE, GRANT, NEXT} state_t;

  localparam logic [Q_IDX_WIDTH:0]   NQ_EXT   = (Q_IDX_WIDTH+1)'(NUM_QUEUES);
  localparam logic [Q_IDX_WIDTH-1:0] LAST_IDX = Q_IDX_WIDTH'(NUM_QUEUES - 1);

  state_t                  state_reg;
  logic [WEIGHT_WIDTH-1:0] weight_reg [NUM_QUEUES];
  logic [WEIGHT_WIDTH-1:0] credit_reg;
  logic [Q_IDX_WIDTH-1:0]  ptr_reg;
  logic [Q_IDX_WIDTH-1:0]  grant_idx_reg;
  logic [NUM_QUEUES-1:0]   grant_reg;
  logic                    grant_valid_reg;
  logic                    round_done_reg;

  logic [NUM_QUEUES-1:0]   eligible;
  logic [Q_IDX_WIDTH:0]    cand;
  logic [Q_IDX_WIDTH-1:0]  win_idx;
  logic                    win_found;
  logic [Q_IDX_WIDTH-1:0]  ptr_next;
  logic                    ptr_wrap;
  logic                    eop;

  always_ff @(posedge axis_aclk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (!axis_resetn)
        weight_reg[i] <= WEIGHT_WIDTH'(1);
      else if (weight_load)
        weight_reg[i] <= weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_elig
      assign eligible[gi] = req[gi] & (weight_reg[gi] != '0);
    end
  endgenerate

  // Scan from farthest to nearest so the last hit is the queue closest to ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (Q_IDX_WIDTH+1)'(k);
      if (cand >= NQ_EXT)
        cand = cand - NQ_EXT;
      if (eligible[cand[Q_IDX_WIDTH-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[Q_IDX_WIDTH-1:0];
      end
    end
  end

  assign ptr_wrap = (grant_idx_reg == LAST_IDX);
  assign ptr_next = ptr_wrap ? '0 : grant_idx_reg + 1'b1;
  assign eop      = out_tvalid & out_tready & out_tlast & grant_valid_reg;

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      grant_idx_reg   <= '0;
      grant_valid_reg <= 1'b0;
      round_done_reg  <= 1'b0;
      ptr_reg         <= '0;
      credit_reg      <= '0;
    end else begin
      round_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            grant_reg       <= NUM_QUEUES'(1) << win_idx;
            grant_idx_reg   <= win_idx;
            grant_valid_reg <= 1'b1;
            credit_reg      <= weight_reg[win_idx] - 1'b1;
            state_reg       <= GRANT;
          end
        end
        GRANT: begin
          // req is ignored here so a packet is never split across queues.
          if (eop) begin
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            state_reg       <= NEXT;
          end
        end
        NEXT: begin
          if (req[grant_idx_reg] && (credit_reg != '0) && (weight_reg[grant_idx_reg] != '0)) begin
            grant_reg       <= NUM_QUEUES'(1) << grant_idx_reg;
            grant_valid_reg <= 1'b1;
            credit_reg      <= credit_reg - 1'b1;
            state_reg       <= GRANT;
          end else begin
            ptr_reg        <= ptr_next;
            round_done_reg <= ptr_wrap;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = grant_idx_reg;
  assign grant_valid = grant_valid_reg;
  assign round_done  = round_done_reg;

endmodule

// File: tb/tb_wrr_pkt_scheduler.sv
// Scoreboard bench for wrr_pkt_scheduler: expected grant order and grant latency are queued
// as each scenario is driven, then popped and compared as the DUT issues grants.
module tb_wrr_pkt_scheduler;

  logic       axis_aclk = 1'b0;
  logic       axis_resetn;
  logic [1:0] req;
  logic [7:0] weights;
  logic       weight_load;
  logic       out_tvalid;
  logic       out_tready;
  logic       out_tlast;
  logic [1:0] grant;
  logic [0:0] grant_idx;
  logic       grant_valid;
  logic       round_done;

  wrr_pkt_scheduler #(.NUM_QUEUES(2), .WEIGHT_WIDTH(4)) dut (
    .axis_aclk   (axis_aclk),
    .axis_resetn (axis_resetn),
    .req         (req),
    .weights     (weights),
    .weight_load (weight_load),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tlast   (out_tlast),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .round_done  (round_done)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct {
    int idx;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   rd_count = 0;
  int   q_cnt [2] = '{0, 0};

  always @(posedge axis_aclk)
    if (round_done === 1'b1) rd_count++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_aclk);
    #1;
    weight_load = 1'b0;
  endtask

  task automatic push_exp(input int idx, input int gap);
    exp_t e;
    e.idx = idx;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic load_weights(input logic [3:0] w1, input logic [3:0] w0);
    weights     = {w1, w0};
    weight_load = 1'b1;
    tick();
  endtask

  // act: 0 none, 1 swap req to q1 only, 2 load q0=5/q1=1, 3 reset pulse (ends the packet)
  task automatic do_pkt(input int beats, input int act_beat, input int act);
    int   gap;
    exp_t e;
    gap = 0;
    while (!grant_valid && gap < 64) begin
      tick();
      gap++;
    end
    check_val("grant_timeout", grant_valid, 1);
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    q_cnt[grant_idx]++;
    $display("pkt q%0d beats=%0d gap=%0d", grant_idx, beats, gap);
    check_val("grant_idx", grant_idx, e.idx);
    check_val("grant_onehot", grant, 32'(1) << e.idx);
    check_val("grant_gap", gap, e.gap);
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    for (int b = 1; b <= beats; b++) begin
      out_tlast = (b == beats);
      if (b == act_beat) begin
        if (act == 1) req = 2'b10;
        if (act == 2) begin
          weights     = {4'd1, 4'd5};
          weight_load = 1'b1;
        end
        if (act == 3) axis_resetn = 1'b0;
      end
      if (b > 1) check_val("grant_held", grant, 32'(1) << e.idx);
      tick();
      if (act == 3 && b == act_beat) begin
        check_val("rst_grant", grant, 0);
        check_val("rst_valid", grant_valid, 0);
        check_val("rst_idx", grant_idx, 0);
        axis_resetn = 1'b1;
        out_tvalid  = 1'b0;
        out_tlast   = 1'b0;
        return;
      end
    end
    check_val("eop_drop", {grant_valid, grant}, 0);
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
  endtask

  task automatic finish_scenario(input string tag, input int rd_start, input int rd_exp);
    req = 2'b00;
    repeat (3) tick();
    check_val(tag, rd_count - rd_start, rd_exp);
  endtask

  initial begin
    int rd0;
    axis_resetn = 1'b0;
    req         = 2'b00;
    weights     = 8'h00;
    weight_load = 1'b0;
    out_tvalid  = 1'b0;
    out_tready  = 1'b0;
    out_tlast   = 1'b0;
    repeat (2) tick();
    check_val("reset_grant", grant, 0);
    check_val("reset_valid", grant_valid, 0);
    check_val("reset_idx", grant_idx, 0);
    check_val("reset_rdone", round_done, 0);
    axis_resetn = 1'b1;
    tick();

    // Equal weights alternate, 3-beat packets.
    rd0 = rd_count;
    req = 2'b11;
    push_exp(0, 1); push_exp(1, 2); push_exp(0, 2); push_exp(1, 2);
    repeat (4) do_pkt(3, 0, 0);
    finish_scenario("s1_round_done", rd0, 2);

    // q0=3, q1=1, single-beat packets.
    load_weights(4'd1, 4'd3);
    rd0 = rd_count;
    q_cnt = '{0, 0};
    req = 2'b11;
    push_exp(0, 1); push_exp(0, 1); push_exp(0, 1); push_exp(1, 2);
    push_exp(0, 2); push_exp(0, 1); push_exp(0, 1); push_exp(1, 2);
    repeat (8) do_pkt(1, 0, 0);
    check_val("s2_q0_count", q_cnt[0], 6);
    check_val("s2_q1_count", q_cnt[1], 2);
    finish_scenario("s2_round_done", rd0, 2);

    // Zero weight is never selected.
    load_weights(4'd2, 4'd0);
    rd0 = rd_count;
    req = 2'b01;
    repeat (10) tick();
    check_val("s3_w0_blocked", {grant_valid, grant}, 0);
    req = 2'b11;
    push_exp(1, 1);
    do_pkt(1, 0, 0);
    finish_scenario("s3_round_done", rd0, 1);

    // req swap mid-packet: q0 keeps the grant until tlast, then forfeits credit.
    load_weights(4'd1, 4'd3);
    rd0 = rd_count;
    req = 2'b01;
    push_exp(0, 1); push_exp(1, 2);
    do_pkt(4, 2, 1);
    do_pkt(1, 0, 0);
    finish_scenario("s4_round_done", rd0, 1);

    // Weight reload while q0 holds zero credit.
    load_weights(4'd1, 4'd1);
    rd0 = rd_count;
    req = 2'b11;
    push_exp(0, 1); push_exp(1, 2); push_exp(0, 2);
    push_exp(0, 1); push_exp(0, 1); push_exp(0, 1); push_exp(0, 1); push_exp(1, 2);
    do_pkt(2, 1, 2);
    repeat (7) do_pkt(1, 0, 0);
    finish_scenario("s5_round_done", rd0, 2);

    // Reset mid-packet: weights return to 1 and the search restarts at q0.
    req = 2'b10;
    push_exp(1, 1);
    do_pkt(4, 2, 3);
    rd0 = rd_count;
    req = 2'b11;
    push_exp(0, 1); push_exp(1, 2);
    do_pkt(1, 0, 0);
    do_pkt(1, 0, 0);
    finish_scenario("s6_round_done", rd0, 1);

    check_val("sb_leftover", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
